instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter DATA_W, 16, instruction width in bits.
REQ-002 Parameter ADDR_W, 4, fetch/load address width.
REQ-003 Parameter DEPTH, 16, number of words (1..2**ADDR_W); addresses >= DEPTH are out of range.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 fetch_en  input  1  fetch request (IR enable) for this cycle.
REQ-007 fetch_addr  input  ADDR_W  word address to fetch.
REQ-008 instruction  output  DATA_W  registered fetch data.
REQ-009 instr_valid  output  1  instruction holds data for the fetch accepted in the previous cycle.
REQ-010 addr_err  output  1  previous accepted fetch was out of range.
REQ-011 load_start  input  1  one-cycle pulse starting a program load.
REQ-012 load_base  input  ADDR_W  first word address of a load, sampled with load_start.
REQ-013 load_len  input  ADDR_W+1  number of words to load, sampled with load_start.
REQ-014 load_valid  input  1  load_data is valid.
REQ-015 load_data  input  DATA_W  word to write.
REQ-016 load_ready  output  1  block accepts load_data this cycle.
REQ-017 busy  output  1  loader is not IDLE.
REQ-018 load_done  output  1  one-cycle pulse when the final word is written.

Function
REQ-019 States: IDLE, LOAD, DONE; the state register resets to IDLE.
REQ-020 IDLE -> LOAD on load_start with load_len != 0; load_start with load_len == 0 goes IDLE -> DONE and writes nothing.
REQ-021 In LOAD, load_ready = 1; a word is written when load_valid && load_ready, at the current write pointer, which then increments.
REQ-022 Write pointer wraps from DEPTH-1 to 0; a load_base >= DEPTH is reduced modulo DEPTH at load_start.
REQ-023 LOAD -> DONE on the cycle that writes word number load_len; DONE -> IDLE unconditionally the next cycle; load_done = 1 only in DONE.
REQ-024 load_start while busy is ignored.
REQ-025 Fetch is accepted when fetch_en && !busy; it yields instruction = mem[fetch_addr] and instr_valid = 1 on the next cycle (1-cycle latency).
REQ-026 Out-of-range accepted fetch yields instruction = 0 (NOP), instr_valid = 1, addr_err = 1.
REQ-027 With no accepted fetch, instr_valid = 0, addr_err = 0, and instruction holds its last value.
REQ-028 Fetch while busy is not accepted: instr_valid = 0 next cycle (fetch stalls).
REQ-029 A fetch accepted in the same cycle as load_start sees the memory contents before the load.
REQ-030 Memory contents initialise at time zero to the default program; words not listed are 0.
REQ-031 Default program, words 0-7: 0xA016, 0x9516, 0x5085, 0x6587, 0x8072, 0x5010, 0x5012, 0xB000.
REQ-032 Reads and writes are synchronous; no combinational path from fetch_addr to instruction.

Reset
REQ-033 While rst_n = 0, the following outputs are 0: instruction, instr_valid, addr_err, load_ready, busy and load_done.
REQ-034 Reset mid-load aborts to IDLE, clears the write pointer and count, and drops load_done.
REQ-035 Reset does not modify memory contents; words already written by an aborted load are retained.
REQ-036 Outputs return to normal operation on the first clock edge after rst_n rises.

Verification
REQ-037 Reset, then fetch_en=1, addr=0,1,7,8 on consecutive cycles -> the fetch data is 0xA016, 0x9516 and 0xB000, then 0x0000, one cycle later each, with instr_valid=1 for all four fetches.
REQ-038 DEPTH=12, fetch addr=13 -> instruction=0, instr_valid=1, addr_err=1 next cycle.
REQ-039 load_start with base=14, len=4, DEPTH=16, then data 0x1111, 0x2222, 0x3333, 0x4444 with valid gapped every other cycle:
  - words land at 14, 15, 0, 1;
  - load_done pulses once;
  - a subsequent fetch of 0 returns 0x3333.
REQ-040 fetch_en held during a load -> instr_valid=0 throughout busy; the first fetch after DONE returns the new data.
REQ-041 rst_n low after 2 of 4 load words -> busy=0 immediately, no load_done, and the 2 written words remain readable.
REQ-042 load_start with len=0 -> busy=1 for exactly one cycle with load_done=1, and no memory change.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction memory with a registered 1-cycle fetch port and a streaming program loader.
// The loader owns the write port; fetches stall while a load is in progress.
module instr_mem_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              addr_err,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              busy,
  output logic              load_done
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W:0]   ONE     = (ADDR_W+1)'(1);

  function automatic mem_t default_prog();
    logic [15:0] prog [8];
    mem_t p;
    prog = '{16'hA016, 16'h9516, 16'h5085, 16'h6587,
             16'h8072, 16'h5010, 16'h5012, 16'hB000};
    p = '0;
    for (int i = 0; i < 8; i++)
      if (i < DEPTH) p[ADDR_W'(i)] = DATA_W'(prog[3'(i)]);
    return p;
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_base(input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] m;
    m = {1'b0, b} % DEPTH_W;
    return m[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? '0 : p + ADDR_W'(1);
  endfunction

  // Contents come up holding the boot program and are never touched by reset.
  mem_t mem = default_prog();

  state_t            state, state_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_W:0]   rem, rem_n;
  logic              we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rem    <= '0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr_n;
      rem    <= rem_n;
    end
  end

  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    rem_n    = rem;
    we       = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          wr_ptr_n = wrap_base(load_base);
          rem_n    = load_len;
          state_n  = (load_len != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (load_valid) begin
          we       = 1'b1;
          wr_ptr_n = next_ptr(wr_ptr);
          rem_n    = rem - ONE;
          if (rem == ONE) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign load_ready = (state == LOAD);
  assign load_done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= load_data;
  end

  logic              accept_p0, in_range_p0;
  logic [DATA_W-1:0] instr_p1;
  logic              vld_p1, err_p1;

  assign accept_p0   = fetch_en && !busy;
  assign in_range_p0 = ({1'b0, fetch_addr} < DEPTH_W);

  // p0 -> p1: registered read; out-of-range fetches return a NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;
      err_p1 <= accept_p0 && !in_range_p0;
      if (accept_p0) instr_p1 <= in_range_p0 ? mem[fetch_addr] : '0;
    end
  end

  assign instruction = instr_p1;
  assign instr_valid = vld_p1;
  assign addr_err    = err_p1;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: fetch path, wrapped gapped load, reset abort, empty load.
// A second instance with DEPTH=12 covers the out-of-range fetch.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [3:0]  fetch_addr;
  logic [15:0] instruction;
  logic        instr_valid, addr_err;
  logic        load_start;
  logic [3:0]  load_base;
  logic [4:0]  load_len;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready, busy, load_done;

  logic        f12_en;
  logic [3:0]  f12_addr;
  logic [15:0] i12;
  logic        v12, e12, r12, b12, d12;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instruction(instruction), .instr_valid(instr_valid), .addr_err(addr_err),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .busy(busy), .load_done(load_done)
  );

  instr_mem_loader #(.DATA_W(16), .ADDR_W(4), .DEPTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .fetch_en(f12_en), .fetch_addr(f12_addr),
    .instruction(i12), .instr_valid(v12), .addr_err(e12),
    .load_start(1'b0), .load_base(4'd0), .load_len(5'd0),
    .load_valid(1'b0), .load_data(16'h0), .load_ready(r12),
    .busy(b12), .load_done(d12)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fetch_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    fetch_en = 1'b1; fetch_addr = a;
    step();
    chk({tag, "_data"}, 32'(instruction), 32'(exp));
    chk({tag, "_vld"},  32'(instr_valid), 32'd1);
    fetch_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
    load_start = 1'b0; load_base = '0; load_len = '0;
    load_valid = 1'b0; load_data = '0;
    f12_en = 1'b0; f12_addr = '0;
    step(); step();
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_vld",   32'(instr_valid), 0);
    chk("rst_err",   32'(addr_err),    0);
    chk("rst_ready", 32'(load_ready),  0);
    chk("rst_busy",  32'(busy),        0);
    chk("rst_done",  32'(load_done),   0);
    chk("rst12_ctl", 32'({r12, b12, d12, v12}), 0);
    rst_n = 1'b1;
    step();

    // Back-to-back fetches of 0,1,7,8 then 2, then an idle cycle holds the data.
    fetch_en = 1'b1; fetch_addr = 4'd0;
    step(); chk("f0", 32'(instruction), 32'hA016); chk("f0_vld", 32'(instr_valid), 1);
    fetch_addr = 4'd1;
    step(); chk("f1", 32'(instruction), 32'h9516); chk("f1_vld", 32'(instr_valid), 1);
    fetch_addr = 4'd7;
    step(); chk("f7", 32'(instruction), 32'hB000); chk("f7_vld", 32'(instr_valid), 1);
    fetch_addr = 4'd8;
    step(); chk("f8", 32'(instruction), 32'h0000); chk("f8_vld", 32'(instr_valid), 1);
    chk("f8_err", 32'(addr_err), 0);
    fetch_addr = 4'd2;
    step(); chk("f2", 32'(instruction), 32'h5085);
    fetch_en = 1'b0;
    step(); chk("hold_data", 32'(instruction), 32'h5085); chk("hold_vld", 32'(instr_valid), 0);

    // Out-of-range fetch on the DEPTH=12 instance.
    f12_en = 1'b1; f12_addr = 4'd3;
    step(); chk("d12_f3", 32'(i12), 32'h6587); chk("d12_f3_err", 32'(e12), 0);
    f12_addr = 4'd13;
    step(); chk("d12_f13", 32'(i12), 0); chk("d12_f13_vld", 32'(v12), 1);
    chk("d12_f13_err", 32'(e12), 1);
    f12_en = 1'b0;
    step(); chk("d12_idle_err", 32'(e12), 0); chk("d12_idle_vld", 32'(v12), 0);

    // Wrapped load at base 14, gapped data, fetch of 0 held throughout.
    load_start = 1'b1; load_base = 4'd14; load_len = 5'd4;
    fetch_en = 1'b1; fetch_addr = 4'd0;
    step();
    chk("ld_fetch_old", 32'(instruction), 32'hA016); chk("ld_fetch_vld", 32'(instr_valid), 1);
    chk("ld_busy", 32'(busy), 1); chk("ld_ready", 32'(load_ready), 1);
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = 16'h1111 * 16'(i + 1);
      step();
      load_valid = 1'b0;
      chk("ld_stall_vld", 32'(instr_valid), 0);
      chk("ld_done_flag", 32'(load_done), (i == 3) ? 1 : 0);
      chk("ld_busy_w", 32'(busy), 1);
      if (i != 3) begin
        step();
        chk("ld_gap_vld", 32'(instr_valid), 0);
        chk("ld_gap_done", 32'(load_done), 0);
      end
    end
    chk("ld_done_ready", 32'(load_ready), 0);
    step();
    chk("ld_idle_busy", 32'(busy), 0); chk("ld_idle_done", 32'(load_done), 0);
    chk("ld_idle_vld", 32'(instr_valid), 0);
    step();
    chk("post_f0", 32'(instruction), 32'h3333); chk("post_f0_vld", 32'(instr_valid), 1);
    fetch_en = 1'b0;
    fetch_chk("post_f1", 4'd1, 16'h4444);
    fetch_chk("post_f14", 4'd14, 16'h1111);
    fetch_chk("post_f15", 4'd15, 16'h2222);

    // Reset after two of four words.
    load_start = 1'b1; load_base = 4'd4; load_len = 5'd4;
    step();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 16'hAAAA;
    step();
    load_data = 16'hBBBB;
    step();
    load_valid = 1'b0;
    chk("ab_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("ab_busy", 32'(busy), 0); chk("ab_ready", 32'(load_ready), 0);
    chk("ab_done", 32'(load_done), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ab_done_after", 32'(load_done), 0); chk("ab_busy_after", 32'(busy), 0);
    fetch_chk("ab_f4", 4'd4, 16'hAAAA);
    fetch_chk("ab_f5", 4'd5, 16'hBBBB);
    fetch_chk("ab_f6", 4'd6, 16'h5012);

    // Empty load: one DONE cycle, nothing written even with data offered.
    load_start = 1'b1; load_base = 4'd2; load_len = 5'd0;
    step();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 16'hFFFF;
    chk("z_busy", 32'(busy), 1); chk("z_done", 32'(load_done), 1);
    chk("z_ready", 32'(load_ready), 0);
    step();
    load_valid = 1'b0;
    chk("z_busy_end", 32'(busy), 0); chk("z_done_end", 32'(load_done), 0);
    fetch_chk("z_f2", 4'd2, 16'h5085);
    fetch_chk("z_f3", 4'd3, 16'h6587);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
